// File: rtl/xlink_bus_arbiter.sv
// Round-robin arbiter that shares one register bus between NUM_REQ link processors.
// Only one transaction is in flight at a time: IDLE -> ISSUE -> (CAPTURE) -> ACK.
module xlink_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*31-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [31:0]            req_rdata,
  output logic [30:0]            addr,
  output logic [31:0]            data_bus_wr,
  input  logic [31:0]            data_bus_rd,
  output logic                   wr_strobe,
  output logic                   rd_strobe,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_idx
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t                      state;
  logic                        wflag;
  logic [IDX_W-1:0]            last_grant;
  logic [IDX_W-1:0]            pick;
  logic [IDX_W-1:0]            cand_idx;
  logic                        found;
  int                          cand;
  logic [NUM_REQ-1:0][30:0]    addr_a;
  logic [NUM_REQ-1:0][31:0]    wdata_a;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign addr_a[g]  = req_addr[31*g +: 31];
    assign wdata_a[g] = req_wdata[32*g +: 32];
  end

  // Scan from the requester after the last one served, wrapping, so the
  // most recently served requester has the lowest priority.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand     = 0;
    cand_idx = '0;
    for (int o = 1; o <= NUM_REQ; o++) begin
      cand     = (int'(last_grant) + o) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_valid[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wflag       <= 1'b0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      grant_idx   <= '0;
      addr        <= '0;
      data_bus_wr <= '0;
      req_rdata   <= '0;
      req_ack     <= '0;
      wr_strobe   <= 1'b0;
      rd_strobe   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      req_ack   <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_idx   <= pick;
            addr        <= addr_a[pick];
            data_bus_wr <= wdata_a[pick];
            wflag       <= req_write[pick];
            wr_strobe   <= req_write[pick];
            rd_strobe   <= !req_write[pick];
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (wflag) begin
            req_ack <= NUM_REQ'(1) << grant_idx;
            state   <= ACK;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // Bus read data is valid the cycle after rd_strobe.
          req_rdata <= data_bus_rd;
          req_ack   <= NUM_REQ'(1) << grant_idx;
          state     <= ACK;
        end
        ACK: begin
          last_grant <= grant_idx;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xlink_bus_arbiter.sv
// Scoreboard bench: drivers push expected transactions per requester; a monitor
// predicts round-robin grants, bus payloads, ack timing and read data.
module tb_xlink_bus_arbiter;
  localparam int N  = 3;
  localparam int IW = 2;

  typedef struct packed {
    logic        wr;
    logic [30:0] a;
    logic [31:0] d;
  } txn_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_write, req_ack;
  logic [N*31-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [31:0]     req_rdata, data_bus_wr, data_bus_rd;
  logic [30:0]     addr;
  logic            wr_strobe, rd_strobe, busy;
  logic [IW-1:0]   grant_idx;

  int   ncmp = 0, nerr = 0, cyc = 0;
  logic [N-1:0] vld_at_edge = '0;
  txn_t exp_q [N][$];

  xlink_bus_arbiter #(.NUM_REQ(N), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
    .req_rdata(req_rdata), .addr(addr), .data_bus_wr(data_bus_wr),
    .data_bus_rd(data_bus_rd), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
    .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    vld_at_edge <= req_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    ncmp++;
    nerr++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Register contents of the shared bus, as seen by a read.
  function automatic logic [31:0] bus_val(input logic [30:0] a);
    if (a == 31'h20) return 32'h12345678;
    return {a, 1'b1} ^ 32'h9E3779B9;
  endfunction

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int o = 1; o <= N; o++)
      if (v[(last + o) % N]) return (last + o) % N;
    return -1;
  endfunction

  task automatic issue(input int i, input logic wr, input logic [30:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = wr; t.a = a; t.d = d;
    req_write[i]         = wr;
    req_addr[31*i +: 31] = a;
    req_wdata[32*i +: 32] = d;
    req_valid[i]         = 1'b1;
    exp_q[i].push_back(t);
  endtask

  // Bus slave: returns data for the strobed address in the cycle after rd_strobe,
  // and garbage at all other times.
  initial begin : responder
    logic seen;
    logic [30:0] sa;
    data_bus_rd = '0;
    forever begin
      @(negedge clk);
      seen = rd_strobe;
      sa   = addr;
      @(posedge clk);
      #1;
      data_bus_rd = seen ? bus_val(sa) : $urandom;
    end
  end

  initial begin : monitor
    int   w, fly_w, fly_ack, model_last;
    logic fly_rd;
    logic [31:0] model_rdata;
    fly_w = -1; fly_ack = 0; fly_rd = 1'b0; model_last = N - 1; model_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        fly_w = -1; model_last = N - 1; model_rdata = '0;
        chk("rst_ack", {29'b0, req_ack}, 0);
        chk("rst_strobes", {30'b0, wr_strobe, rd_strobe}, 0);
        continue;
      end
      chk("one_strobe", {31'b0, wr_strobe & rd_strobe}, 0);
      chk("ack_onehot0", {31'b0, $countones(req_ack) <= 1}, 1);
      if (fly_w >= 0 && exp_q[fly_w].size() > 0)
        chk("addr_stable", {1'b0, addr}, {1'b0, exp_q[fly_w][0].a});
      if (wr_strobe || rd_strobe) begin
        w = rr_pick(model_last, vld_at_edge);
        if (fly_w >= 0) flag("overlapping_strobe");
        if (w < 0 || exp_q[w < 0 ? 0 : w].size() == 0) flag("spurious_grant");
        else begin
          chk("grant_idx", {30'b0, grant_idx}, w);
          chk("strobe_kind", {31'b0, wr_strobe}, {31'b0, exp_q[w][0].wr});
          chk("bus_addr", {1'b0, addr}, {1'b0, exp_q[w][0].a});
          if (exp_q[w][0].wr) chk("bus_wdata", data_bus_wr, exp_q[w][0].d);
          chk("busy_issue", {31'b0, busy}, 1);
          fly_w = w; fly_rd = !exp_q[w][0].wr;
          fly_ack = cyc + (fly_rd ? 2 : 1);
          model_last = w;
        end
      end
      if (req_ack != '0) begin
        if (fly_w < 0) flag("spurious_ack");
        else begin
          chk("ack_bit", {29'b0, req_ack}, 32'(1) << fly_w);
          chk("ack_latency", cyc, fly_ack);
          if (fly_rd) model_rdata = bus_val(exp_q[fly_w][0].a);
          chk("rdata", req_rdata, model_rdata);
          chk("busy_ack", {31'b0, busy}, 1);
          void'(exp_q[fly_w].pop_front());
          fly_w = -1;
        end
      end else if (fly_w >= 0 && cyc > fly_ack) begin
        flag("missing_ack");
        void'(exp_q[fly_w].pop_front());
        fly_w = -1;
      end
    end
  end

  task automatic wait_ack(input int i, output int s_cyc, output int a_cyc);
    s_cyc = -1; a_cyc = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((wr_strobe || rd_strobe) && int'(grant_idx) == i && s_cyc < 0) s_cyc = cyc;
      if (req_ack[i]) begin
        a_cyc = cyc;
        req_valid[i] = 1'b0;
        break;
      end
    end
    if (a_cyc < 0) flag("wait_ack_timeout");
  endtask

  task automatic next_ack(output int idx);
    idx = -1;
    for (int k = 0; k < 60 && idx < 0; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (req_ack[i]) idx = i;
    end
    if (idx < 0) flag("next_ack_timeout");
    else req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (req_ack[i]) req_valid[i] = 1'b0;
      if (req_valid == '0 && !busy) done = 1;
    end
    if (!done) flag("drain_timeout");
  endtask

  task automatic rand_driver(input int i);
    bit seen, got;
    repeat (30) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      issue(i, 1'($urandom), 31'($urandom), $urandom);
      seen = 0; got = 0;
      for (int k = 0; k < 200 && !got; k++) begin
        @(negedge clk);
        if (!seen && (wr_strobe || rd_strobe) && int'(grant_idx) == i) begin
          seen = 1;
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b0;
            req_addr[31*i +: 31] = 31'($urandom);
            req_wdata[32*i +: 32] = $urandom;
          end
        end
        if (req_ack[i]) begin
          req_valid[i] = 1'b0;
          got = 1;
        end
      end
      if (!got) flag("rand_ack_timeout");
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0, s, a, idx, n0, left;
    reset = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr", {1'b0, addr}, 0);
    chk("rst_wdata", data_bus_wr, 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_grant", {30'b0, grant_idx}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    reset = 1'b1;

    // T1 single write from requester 0
    @(posedge clk); #1; c0 = cyc;
    issue(0, 1'b1, 31'h10, 32'hDEADBEEF);
    wait_ack(0, s, a);
    chk("t1_strobe_lat", s, c0 + 1);
    chk("t1_ack_lat", a, c0 + 2);

    // T2 single read from requester 1
    @(posedge clk); #1; c0 = cyc;
    issue(1, 1'b0, 31'h20, 32'h0BADF00D);
    wait_ack(1, s, a);
    chk("t2_strobe_lat", s, c0 + 1);
    chk("t2_ack_lat", a, c0 + 3);
    chk("t2_rdata", req_rdata, 32'h12345678);

    // T4 requester 0 drops valid and scrambles payload during ISSUE
    @(posedge clk); #1;
    issue(0, 1'b1, 31'h0ABC, 32'hCAFE0001);
    s = -1;
    for (int k = 0; k < 20 && s < 0; k++) begin
      @(negedge clk);
      if (wr_strobe && grant_idx == 0) s = cyc;
    end
    if (s < 0) flag("t4_no_grant");
    req_valid[0] = 1'b0;
    req_addr[30:0] = 31'h7FFF; req_wdata[31:0] = 32'h1;
    n0 = 0;
    repeat (12) begin
      @(negedge clk);
      n0 += int'(req_ack[0]);
    end
    chk("t4_ack_once", n0, 1);

    // T5 reset during CAPTURE of a read from 1 while 0 waits
    @(posedge clk); #1;
    issue(1, 1'b0, 31'h33, 32'h0);
    s = -1;
    for (int k = 0; k < 20 && s < 0; k++) begin
      @(negedge clk);
      if (rd_strobe && grant_idx == 1) s = cyc;
    end
    if (s < 0) flag("t5_no_grant");
    issue(0, 1'b1, 31'h44, 32'h55667788);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_addr", {1'b0, addr}, 0);
    chk("t5_wdata", data_bus_wr, 0);
    chk("t5_rdata", req_rdata, 0);
    chk("t5_grant", {30'b0, grant_idx}, 0);
    chk("t5_busy", {31'b0, busy}, 0);
    chk("t5_ctrl", {27'b0, req_ack, wr_strobe, rd_strobe}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    next_ack(idx); chk("t5_first", idx, 0);
    next_ack(idx); chk("t5_second", idx, 1);
    drain();

    // T6 wrap: serve 2, then 0 and 2 together -> 0 first
    @(posedge clk); #1;
    issue(2, 1'b1, 31'h60, 32'h6);
    wait_ack(2, s, a);
    @(posedge clk); #1;
    issue(0, 1'b0, 31'h61, 32'h0);
    issue(2, 1'b1, 31'h62, 32'h62);
    next_ack(idx); chk("t6_first", idx, 0);
    next_ack(idx); chk("t6_second", idx, 2);
    drain();

    // T3 requesters 0 and 1 asserted continuously from reset
    @(negedge clk);
    reset = 1'b0;
    issue(0, 1'($urandom), 31'($urandom), $urandom);
    issue(1, 1'($urandom), 31'($urandom), $urandom);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      next_ack(idx);
      chk("t3_order", idx, k % 2);
      if (k < 7 && idx >= 0) issue(idx, 1'($urandom), 31'($urandom), $urandom);
    end
    drain();

    // Randomized traffic from all requesters
    fork
      rand_driver(0);
      rand_driver(1);
      rand_driver(2);
    join
    drain();
    repeat (4) @(negedge clk);
    left = 0;
    for (int i = 0; i < N; i++) left += exp_q[i].size();
    chk("leftover_txns", left, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
